ewrapper_io_rx_deser: RTL and testbench



---
 rtl/ewrapper_io_rx_deser_pkg.sv | 35 +++
 rtl/ewrapper_io_rx_deser_if.sv | 21 ++
 rtl/erx_frame_detect.sv | 44 ++++
 rtl/ewrapper_io_rx_deser.sv | 94 +++++++++
 tb/tb_ewrapper_io_rx_deser.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ewrapper_io_rx_deser_pkg.sv
// Shared constants, state encoding and lane-pair types for the eLink receive deserializer.
package ewrapper_io_rx_deser_pkg;

  localparam int unsigned LANES          = 9;
  localparam int unsigned WORD_W         = 72;
  localparam int unsigned PAIRS_PER_WORD = 4;
  localparam int unsigned PHASE_W        = 2;

  localparam logic [7:0] FRAME_START_DEFAULT = 8'h3F;
  localparam logic [7:0] IDLE_BYTE           = 8'h00;
  localparam logic [7:0] BUSY_BYTE           = 8'hFF;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

  // One IDDR capture: first-in-time and second-in-time bit of every lane.
  typedef struct packed {
    logic [LANES-1:0] even;
    logic [LANES-1:0] odd;
  } lane_pair_t;

  // Index 0 is the oldest pair of the window, index 3 the newest.
  typedef lane_pair_t [PAIRS_PER_WORD-1:0] pair_win_t;

  // Reassemble one lane's byte; the first bit on the wire lands in the MSB.
  function automatic logic [7:0] lane_byte(input pair_win_t win, input logic [3:0] lane);
    return {win[0].even[lane], win[0].odd[lane],
            win[1].even[lane], win[1].odd[lane],
            win[2].even[lane], win[2].odd[lane],
            win[3].even[lane], win[3].odd[lane]};
  endfunction

endpackage

// File: rtl/ewrapper_io_rx_deser_if.sv
// Lane inputs from the IDDR stage and word outputs toward the receive FIFO.
interface ewrapper_io_rx_deser_if;
  import ewrapper_io_rx_deser_pkg::*;

  logic [LANES-1:0]  DATA_EVEN_IN;
  logic [LANES-1:0]  DATA_ODD_IN;
  logic [WORD_W-1:0] DATA_OUT_TO_DEVICE;
  logic              DATA_VALID;
  logic              FRAME_LOCKED;
  logic              FRAME_ERR;

  modport master (
    output DATA_EVEN_IN, DATA_ODD_IN,
    input  DATA_OUT_TO_DEVICE, DATA_VALID, FRAME_LOCKED, FRAME_ERR
  );

  modport slave (
    input  DATA_EVEN_IN, DATA_ODD_IN,
    output DATA_OUT_TO_DEVICE, DATA_VALID, FRAME_LOCKED, FRAME_ERR
  );
endinterface

// File: rtl/erx_frame_detect.sv
// Frame-lane decision logic: start detection in HUNT, boundary checks in LOCKED.
module erx_frame_detect
  import ewrapper_io_rx_deser_pkg::*;
#(
  parameter logic [7:0] FRAME_START = FRAME_START_DEFAULT
) (
  input  logic [7:0]         frame_byte,
  input  logic [7:0]         prev_frame,
  input  logic [PHASE_W-1:0] phase,
  input  rx_state_e          state,
  output logic               emit_c,
  output logic               go_locked_c,
  output logic               go_hunt_c,
  output logic               err_c
);

  always_comb begin
    emit_c      = 1'b0;
    go_locked_c = 1'b0;
    go_hunt_c   = 1'b0;
    err_c       = 1'b0;
    case (state)
      ST_HUNT: begin
        // A start only counts when the preceding four pairs were idle.
        if ((frame_byte == FRAME_START) && (prev_frame == IDLE_BYTE)) begin
          emit_c      = 1'b1;
          go_locked_c = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (phase == '1) begin
          if (frame_byte == IDLE_BYTE) begin
            go_hunt_c = 1'b1;
          end else begin
            emit_c = 1'b1;
            err_c  = (frame_byte != BUSY_BYTE) && (frame_byte != FRAME_START);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ewrapper_io_rx_deser.sv
// eLink RX deserializer: IDDR even/odd pairs in, frame-aligned 72-bit words out.
module ewrapper_io_rx_deser
  import ewrapper_io_rx_deser_pkg::*;
#(
  parameter bit         INVERT      = 1'b0,
  parameter logic [7:0] FRAME_START = FRAME_START_DEFAULT
) (
  input logic                   CLK_IN,
  input logic                   IO_RESET,
  ewrapper_io_rx_deser_if.slave rx
);

  pair_win_t          pair_hist_q, pair_hist_d;
  logic [7:0]         prev_frame_q, prev_frame_d;
  rx_state_e          state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  lane_pair_t         in_pair_c;
  logic [WORD_W-1:0]  window_c;
  logic               emit_c, go_locked_c, go_hunt_c, err_c;

  assign in_pair_c = lane_pair_t'({rx.DATA_EVEN_IN, rx.DATA_ODD_IN} ^ {(2*LANES){INVERT}});

  // Inverse of the TX serializer's channel-to-byte alignment, one byte per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_map
    assign window_c[8*k +: 8] = lane_byte(pair_hist_q, 4'(k));
  end

  erx_frame_detect #(
    .FRAME_START (FRAME_START)
  ) u_frame_detect (
    .frame_byte  (window_c[WORD_W-1 -: 8]),
    .prev_frame  (prev_frame_q),
    .phase       (phase_q),
    .state       (state_q),
    .emit_c      (emit_c),
    .go_locked_c (go_locked_c),
    .go_hunt_c   (go_hunt_c),
    .err_c       (err_c)
  );

  always_comb begin
    // Pairs leaving the window feed the previous-frame-byte history.
    pair_hist_d  = {in_pair_c, pair_hist_q[PAIRS_PER_WORD-1:1]};
    prev_frame_d = {prev_frame_q[5:0], pair_hist_q[0].even[LANES-1], pair_hist_q[0].odd[LANES-1]};
    state_d      = state_q;
    phase_d      = '0;
    word_d       = word_q;
    valid_d      = emit_c;
    err_d        = err_c;
    if (state_q == ST_LOCKED) begin
      phase_d = phase_q + PHASE_W'(1);
    end
    if (emit_c) begin
      word_d = window_c;
    end
    if (go_locked_c) begin
      state_d = ST_LOCKED;
      phase_d = '0;
    end
    if (go_hunt_c) begin
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      pair_hist_q  <= '0;
      prev_frame_q <= IDLE_BYTE;
      state_q      <= ST_HUNT;
      phase_q      <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pair_hist_q  <= pair_hist_d;
      prev_frame_q <= prev_frame_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      word_q       <= word_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign rx.DATA_OUT_TO_DEVICE = word_q;
  assign rx.DATA_VALID         = valid_q;
  assign rx.FRAME_ERR          = err_q;
  assign rx.FRAME_LOCKED       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
// Scoreboard bench: transactions are serialized with the TX lane mapping and the
// expected words/lock edges are queued; a monitor checks both polarities of the DUT.
module tb_ewrapper_io_rx_deser;
  import ewrapper_io_rx_deser_pkg::*;

  localparam logic [7:0] START = 8'h3F;

  typedef struct { int unsigned cyc; logic [71:0] word; logic err; } exp_t;
  typedef struct { int unsigned cyc; logic level; } lk_t;
  typedef struct { logic [17:0] pair; int kind; logic [71:0] word; logic err; } beat_t;

  logic CLK_IN;
  logic IO_RESET;

  ewrapper_io_rx_deser_if rx0();
  ewrapper_io_rx_deser_if rx1();

  ewrapper_io_rx_deser #(.INVERT(1'b0), .FRAME_START(START)) u_dut0 (
    .CLK_IN(CLK_IN), .IO_RESET(IO_RESET), .rx(rx0.slave));
  ewrapper_io_rx_deser #(.INVERT(1'b1), .FRAME_START(START)) u_dut1 (
    .CLK_IN(CLK_IN), .IO_RESET(IO_RESET), .rx(rx1.slave));

  logic [71:0] dout [2];
  logic        vld  [2];
  logic        lck  [2];
  logic        ferr [2];
  assign dout[0] = rx0.DATA_OUT_TO_DEVICE;
  assign dout[1] = rx1.DATA_OUT_TO_DEVICE;
  assign vld[0]  = rx0.DATA_VALID;
  assign vld[1]  = rx1.DATA_VALID;
  assign lck[0]  = rx0.FRAME_LOCKED;
  assign lck[1]  = rx1.FRAME_LOCKED;
  assign ferr[0] = rx0.FRAME_ERR;
  assign ferr[1] = rx1.FRAME_ERR;

  exp_t        exp_q[$];
  lk_t         lk_q[$];
  beat_t       beat_q[$];
  logic [7:0]  frm_q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rd_e [2];
  int          rd_l [2];
  logic        lk_prev [2];
  logic [71:0] last_dout [2];
  logic        end_req;
  logic        end_done;

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  always @(posedge CLK_IN) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int idx,
                       input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, idx, cyc, act, req);
    end
  endtask

  // TX-side serialization: lane k even bit of pair c is word[8k+7-2c], odd is word[8k+6-2c].
  function automatic logic [17:0] ser_pair(input logic [71:0] w, input int c);
    logic [8:0]  ev;
    logic [8:0]  od;
    logic [71:0] t;
    ev = '0;
    od = '0;
    for (int k = 0; k < 9; k++) begin
      t  = w >> (8*k + 7 - 2*c);
      ev = {t[0], ev[8:1]};
      t  = w >> (8*k + 6 - 2*c);
      od = {t[0], od[8:1]};
    end
    return {ev, od};
  endfunction

  // Word-level model: a start needs FRAME_START after an idle byte; 00 ends the
  // transaction silently; any other byte than FF/FRAME_START is flagged.
  task automatic gen_txn(input int gap, input logic [7:0] pre);
    logic [7:0]  prev;
    logic [7:0]  f;
    bit          locked;
    logic [71:0] w;
    beat_t       b;
    int          kind;
    logic        err;
    int          c;
    for (int n = 0; n < gap; n++) begin
      if (pre != 8'h00 && gap >= 4 && n >= gap - 4) begin
        w = {pre, $urandom, $urandom};
        c = n - (gap - 4);
      end else begin
        w = {8'h00, $urandom, $urandom};
        c = 0;
      end
      b.pair = ser_pair(w, c); b.kind = 0; b.word = w; b.err = 1'b0;
      beat_q.push_back(b);
    end
    prev   = pre;
    locked = 1'b0;
    foreach (frm_q[i]) begin
      f    = frm_q[i];
      w    = {f, $urandom, $urandom};
      kind = 0;
      err  = 1'b0;
      if (!locked) begin
        if (f == START && prev == 8'h00) begin kind = 2; locked = 1'b1; end
      end else if (f == 8'h00) begin
        kind = 3; locked = 1'b0;
      end else begin
        kind = 1; err = (f != 8'hFF) && (f != START);
      end
      prev = f;
      for (int cc = 0; cc < 4; cc++) begin
        b.pair = ser_pair(w, cc); b.kind = (cc == 3) ? kind : 0; b.word = w; b.err = err;
        beat_q.push_back(b);
      end
    end
    frm_q.delete();
  endtask

  // Output for a word whose last pair is driven now is visible two negedges later.
  task automatic drive_n(input int n);
    beat_t b;
    exp_t  e;
    lk_t   l;
    for (int j = 0; j < n && beat_q.size() > 0; j++) begin
      b = beat_q.pop_front();
      @(negedge CLK_IN);
      {rx0.DATA_EVEN_IN, rx0.DATA_ODD_IN} = b.pair;
      {rx1.DATA_EVEN_IN, rx1.DATA_ODD_IN} = ~b.pair;
      if (b.kind == 1 || b.kind == 2) begin
        e.cyc = cyc + 2; e.word = b.word; e.err = b.err;
        exp_q.push_back(e);
      end
      if (b.kind == 2 || b.kind == 3) begin
        l.cyc = cyc + 2; l.level = (b.kind == 2);
        lk_q.push_back(l);
      end
    end
  endtask

  task automatic run_frames4(input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] f2, input logic [7:0] f3,
                             input int gap, input logic [7:0] pre);
    frm_q.push_back(f0); frm_q.push_back(f1); frm_q.push_back(f2); frm_q.push_back(f3);
    gen_txn(gap, pre);
    drive_n(beat_q.size());
  endtask

  always @(negedge CLK_IN) begin
    exp_t e;
    lk_t  l;
    bit   ok;
    for (int i = 0; i < 2; i++) begin
      if (IO_RESET) begin
        check(dout[i] == 72'h0, "reset_data", i, dout[i], 72'h0);
        check({vld[i], lck[i], ferr[i]} == 3'b000, "reset_flags", i,
              72'({vld[i], lck[i], ferr[i]}), 72'h0);
        lk_prev[i]   = 1'b0;
        last_dout[i] = '0;
      end else begin
        if (vld[i]) begin
          ok = (rd_e[i] < exp_q.size());
          check(ok, "strobe_expected", i, 72'(rd_e[i]), 72'(exp_q.size()));
          if (ok) begin
            e = exp_q[rd_e[i]];
            rd_e[i]++;
            check(cyc == e.cyc, "strobe_time", i, 72'(cyc), 72'(e.cyc));
            check(dout[i] == e.word, "word", i, dout[i], e.word);
            check(ferr[i] == e.err, "frame_err", i, 72'(ferr[i]), 72'(e.err));
          end
          last_dout[i] = dout[i];
        end else begin
          check(!ferr[i], "err_without_valid", i, 72'(ferr[i]), 72'h0);
          check(dout[i] == last_dout[i], "data_hold", i, dout[i], last_dout[i]);
        end
        if (lck[i] != lk_prev[i]) begin
          ok = (rd_l[i] < lk_q.size());
          check(ok, "lock_edge_expected", i, 72'(rd_l[i]), 72'(lk_q.size()));
          if (ok) begin
            l = lk_q[rd_l[i]];
            rd_l[i]++;
            check(cyc == l.cyc, "lock_edge_time", i, 72'(cyc), 72'(l.cyc));
            check(lck[i] == l.level, "lock_level", i, 72'(lck[i]), 72'(l.level));
          end
        end
        lk_prev[i] = lck[i];
      end
    end
    if (end_req && !end_done) begin
      for (int i = 0; i < 2; i++) begin
        check(rd_e[i] == exp_q.size(), "strobe_count", i, 72'(rd_e[i]), 72'(exp_q.size()));
        check(rd_l[i] == lk_q.size(), "lock_edge_count", i, 72'(rd_l[i]), 72'(lk_q.size()));
        check(!lck[i], "locked_at_end", i, 72'(lck[i]), 72'h0);
      end
      end_done = 1'b1;
    end
  end

  initial begin
    int          gap;
    int          len;
    logic [7:0]  mid;
    IO_RESET = 1'b1;
    end_req  = 1'b0;
    end_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_e[i] = 0; rd_l[i] = 0; lk_prev[i] = 1'b0; last_dout[i] = '0;
    end
    {rx0.DATA_EVEN_IN, rx0.DATA_ODD_IN} = '0;
    {rx1.DATA_EVEN_IN, rx1.DATA_ODD_IN} = '1;
    repeat (3) @(posedge CLK_IN);
    #2 IO_RESET = 1'b0;

    // Idle then start, then the same start shifted by 1..3 pairs.
    run_frames4(START, 8'hFF, 8'hFF, 8'h00, 8, 8'h00);
    for (int s = 1; s <= 3; s++) run_frames4(START, 8'hFF, 8'hFF, 8'h00, 8 + s, 8'h00);

    // Malformed frame byte in the middle of a transaction.
    run_frames4(START, 8'h5A, 8'hFF, 8'h00, 6, 8'h00);

    // Back-to-back transactions separated only by the idle word.
    frm_q.push_back(START); frm_q.push_back(8'hFF); frm_q.push_back(8'h00);
    frm_q.push_back(START); frm_q.push_back(8'hFF); frm_q.push_back(8'h00);
    gen_txn(5, 8'h00);
    drive_n(beat_q.size());

    // Start pattern not preceded by an idle byte must be ignored.
    run_frames4(START, 8'hFF, 8'hFF, 8'h00, 7, 8'h01);

    // Random transactions: random gaps, lengths, frame bytes and data.
    repeat (6) begin
      gap = int'($urandom_range(4, 11));
      len = int'($urandom_range(1, 5));
      frm_q.push_back(START);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 2))
          0:       mid = 8'hFF;
          1:       mid = START;
          default: mid = 8'($urandom_range(1, 255));
        endcase
        frm_q.push_back(mid);
      end
      frm_q.push_back(8'h00);
      gen_txn(gap, 8'h00);
      drive_n(beat_q.size());
    end

    // Reset right after the second strobe, then a start immediately after release.
    frm_q.push_back(START); frm_q.push_back(8'hFF); frm_q.push_back(8'hFF); frm_q.push_back(8'h00);
    gen_txn(6, 8'h00);
    drive_n(6 + 10);
    @(posedge CLK_IN);
    #2 IO_RESET = 1'b1;
    {rx0.DATA_EVEN_IN, rx0.DATA_ODD_IN} = '0;
    {rx1.DATA_EVEN_IN, rx1.DATA_ODD_IN} = '1;
    beat_q.delete();
    repeat (2) @(posedge CLK_IN);
    #2 IO_RESET = 1'b0;
    run_frames4(START, 8'hFF, 8'hFF, 8'h00, 0, 8'h00);

    gen_txn(16, 8'h00);
    drive_n(beat_q.size());

    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_done; t++) @(posedge CLK_IN);
    if (!end_done) begin
      $display("FAIL end_check: final checks did not complete");
      $fatal(1, "end check timeout");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
